crossbar_arbiter: RTL and testbench
===================================

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

Interface
REQ-001 SHALL have parameter S_DATA_COUNT, default 2: number of input (slave) streams.
REQ-002 SHALL have parameter M_DATA_COUNT, default 3: number of output (master) streams.
REQ-003 SHALL have localparam T_ID___WIDTH = $clog2(S_DATA_COUNT): width of an input index.
REQ-004 SHALL have localparam T_DEST_WIDTH = $clog2(M_DATA_COUNT): width of an output index.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port s_dest_i, input, [T_DEST_WIDTH-1:0] x S_DATA_COUNT: destination output of each input stream.
REQ-008 SHALL have port s_valid_i, input, [S_DATA_COUNT-1:0]: per-input beat valid.
REQ-009 SHALL have port s_last_i, input, [S_DATA_COUNT-1:0]: per-input last beat of packet.
REQ-010 SHALL have port m_ready_i, input, [M_DATA_COUNT-1:0]: per-output downstream ready.
REQ-011 SHALL have port grant_o, output, [T_ID___WIDTH-1:0] x M_DATA_COUNT: input index connected to each output.
REQ-012 SHALL have port arbiter_ready_o, output, [M_DATA_COUNT-1:0]: grant_o[j] is valid and the path to output j is open.

Function
REQ-013 SHALL run one independent arbiter per output j; request vector req_j[i] = s_valid_i[i] && (s_dest_i[i] == j).
REQ-014 SHALL give each arbiter two states: IDLE (arbiter_ready_o[j]=0) and LOCKED (arbiter_ready_o[j]=1).
REQ-015 SHALL, in IDLE with req_j non-zero, select the first requester at index >= ptr_j, searching upward with wrap-around to 0, register it into grant_o[j], and move to LOCKED on the next edge.
REQ-016 SHALL, on that same grant edge, set ptr_j to winner+1, wrapping to 0 when winner == S_DATA_COUNT-1 (non-power-of-two S included).
REQ-017 SHALL remain in IDLE with grant_o[j] and ptr_j unchanged while req_j is zero.
REQ-018 SHALL define a beat transfer on output j in LOCKED as s_valid_i[grant_o[j]] && m_ready_i[j]; s_dest_i is not rechecked while LOCKED.
REQ-019 SHALL return to IDLE on the edge after a transfer with s_last_i[grant_o[j]] = 1; grant_o[j] holds its value while in IDLE.
REQ-020 SHALL hold LOCKED, with grant_o[j] stable, while the granted input drops s_valid_i or m_ready_i[j] is low, for any number of cycles.
REQ-021 SHALL have latency: request first seen in IDLE at cycle n gives arbiter_ready_o[j]=1 from cycle n+1; after a last-beat transfer at cycle n, arbiter_ready_o[j]=0 at cycle n+1, with at least one IDLE cycle between packets.
REQ-022 SHALL resolve simultaneous requests from several inputs for one output purely by ptr_j order; the losers keep requesting and are served later.
REQ-023 SHALL allow all M outputs to be LOCKED concurrently to distinct inputs; one input never holds two outputs, because it has a single s_dest_i.
REQ-024 SHALL treat a single-beat packet (valid and last together) as a complete packet: one LOCKED cycle when m_ready_i[j]=1.

Reset
REQ-025 SHALL, while rst_in=0, asynchronously force every arbiter to IDLE, grant_o[j]=0, arbiter_ready_o[j]=0 and ptr_j=0, including mid-packet.
REQ-026 SHALL start arbitration no earlier than the first clk_i rising edge after rst_in deasserts.

Structure
REQ-027 SHALL place the arb_state_t enum (IDLE, LOCKED) in a shared package crossbar_pkg, for reuse by the crossbar top and benches.
REQ-028 SHALL implement the per-output logic as a sub-module rr_arbiter (parameters S_DATA_COUNT, T_ID___WIDTH), instantiated M_DATA_COUNT times by a generate loop.

Verification
REQ-029 SHALL cover, S=2 M=3: in0 valid, dest=1, last on beat 3, m_ready_i=3'b111 -> grant_o[1]=0 and arbiter_ready_o[1]=1 for exactly 3 cycles, then 0; outputs 0 and 2 stay 0.
REQ-030 SHALL cover: in0 and in1 both dest=2, single-beat packets repeated, reset ptr -> grants alternate 0,1,0,1, each separated by one IDLE cycle.
REQ-031 SHALL cover: granted in1 drops s_valid_i for 4 cycles mid-packet and m_ready_i[0] toggles -> grant_o[0]=1 and arbiter_ready_o[0]=1 held throughout; release only after the last beat transfers.
REQ-032 SHALL cover: in0 to dest 0 and in1 to dest 2 in the same cycle -> both arbiters LOCKED on the next cycle, with grant_o[0]=0 and grant_o[2]=1.
REQ-033 SHALL cover: rst_in pulsed low mid-packet, away from any clock edge -> arbiter_ready_o=0 and grant_o=0 immediately; after release, a fresh request is granted to input 0 first.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar arbiter and its users.
package crossbar_pkg;

    // Per-output arbiter state: IDLE waits for a request, LOCKED owns the path until the last beat.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin packet arbiter for a single crossbar output. Grants one input,
// holds the grant for a whole packet, releases on the transfer of the last beat.
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_in,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic [S_DATA_COUNT-1:0] valid_i,
    input  logic [S_DATA_COUNT-1:0] last_i,
    input  logic                    ready_i,
    output logic [T_ID___WIDTH-1:0] grant_o,
    output logic                    arbiter_ready_o
);

    localparam logic [T_ID___WIDTH-1:0] ZERO_IDX = {T_ID___WIDTH{1'b0}};
    localparam logic [T_ID___WIDTH-1:0] ONE_IDX  = T_ID___WIDTH'(1);
    localparam logic [T_ID___WIDTH-1:0] LAST_IDX = T_ID___WIDTH'(S_DATA_COUNT - 1);

    // Index of the lowest set bit; only meaningful when the vector is non-zero.
    function automatic logic [T_ID___WIDTH-1:0] lowest_set(input logic [S_DATA_COUNT-1:0] vec);
        logic [T_ID___WIDTH-1:0] idx;
        idx = ZERO_IDX;
        for (int i = S_DATA_COUNT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = T_ID___WIDTH'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    arb_state_t              state_q;
    arb_state_t              state_d;
    logic [T_ID___WIDTH-1:0] grant_q;
    logic [T_ID___WIDTH-1:0] grant_d;
    logic [T_ID___WIDTH-1:0] ptr_q;
    logic [T_ID___WIDTH-1:0] ptr_d;

    logic [S_DATA_COUNT-1:0] ge_mask_s;
    logic [S_DATA_COUNT-1:0] upper_req_s;
    logic [T_ID___WIDTH-1:0] winner_s;
    logic [T_ID___WIDTH-1:0] next_ptr_s;
    logic                    xfer_s;

    // Round-robin pick: first requester at or above the pointer, otherwise wrap to the lowest requester.
    always_comb begin
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            ge_mask_s[i] = (T_ID___WIDTH'(i) >= ptr_q);
        end
        upper_req_s = req_i & ge_mask_s;
        winner_s    = (|upper_req_s) ? lowest_set(upper_req_s) : lowest_set(req_i);
        next_ptr_s  = (winner_s == LAST_IDX) ? ZERO_IDX : (winner_s + ONE_IDX);
        xfer_s      = valid_i[grant_q] & ready_i;
    end

    // Next-state logic: grant on any request in IDLE, release after the last beat has transferred.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = LOCKED;
                    grant_d = winner_s;
                    ptr_d   = next_ptr_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && last_i[grant_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and pointer registers; reset clears everything immediately, even mid-packet.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            grant_q <= ZERO_IDX;
            ptr_q   <= ZERO_IDX;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o         = grant_q;
    assign arbiter_ready_o = (state_q == LOCKED);

endmodule

// File: rtl/crossbar_arbiter.sv
// Crossbar arbitration: one independent round-robin packet arbiter per output stream.
module crossbar_arbiter #(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_in,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                   s_last_i,
    input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
    output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_o,
    output logic [M_DATA_COUNT-1:0]                   arbiter_ready_o
);

    for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
        logic [S_DATA_COUNT-1:0] req_s;

        // Inputs with a valid beat addressed to this output form its request vector.
        always_comb begin
            for (int i = 0; i < S_DATA_COUNT; i++) begin
                req_s[i] = s_valid_i[i] && (s_dest_i[i] == T_DEST_WIDTH'(j));
            end
        end

        rr_arbiter #(
            .S_DATA_COUNT (S_DATA_COUNT),
            .T_ID___WIDTH (T_ID___WIDTH)
        ) u_arb (
            .clk_i           (clk_i),
            .rst_in          (rst_in),
            .req_i           (req_s),
            .valid_i         (s_valid_i),
            .last_i          (s_last_i),
            .ready_i         (m_ready_i[j]),
            .grant_o         (grant_o[j]),
            .arbiter_ready_o (arbiter_ready_o[j])
        );
    end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Self-checking bench for crossbar_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_crossbar_arbiter;

    localparam int S  = 2;
    localparam int M  = 3;
    localparam int IW = $clog2(S);
    localparam int DW = $clog2(M);

    logic                  clk_i = 1'b0;
    logic                  rst_in;
    logic [S-1:0][DW-1:0]  s_dest_i;
    logic [S-1:0]          s_valid_i;
    logic [S-1:0]          s_last_i;
    logic [M-1:0]          m_ready_i;
    logic [M-1:0][IW-1:0]  grant_o;
    logic [M-1:0]          arbiter_ready_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state per output, plus per-input transfer flags of the last cycle.
    bit m_locked[M];
    int m_grant[M];
    int m_ptr[M];
    bit fired[S];
    bit fired_last[S];

    logic [M-1:0][IW-1:0] exp_grant;
    logic [M-1:0]         exp_ready;

    crossbar_arbiter #(
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (M)
    ) dut (
        .clk_i           (clk_i),
        .rst_in          (rst_in),
        .s_dest_i        (s_dest_i),
        .s_valid_i       (s_valid_i),
        .s_last_i        (s_last_i),
        .m_ready_i       (m_ready_i),
        .grant_o         (grant_o),
        .arbiter_ready_o (arbiter_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        for (int j = 0; j < M; j++) begin
            m_locked[j] = 1'b0;
            m_grant[j]  = 0;
            m_ptr[j]    = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int  g;
        bit  found;
        for (int i = 0; i < S; i++) begin
            fired[i]      = 1'b0;
            fired_last[i] = 1'b0;
        end
        for (int j = 0; j < M; j++) begin
            if (m_locked[j]) begin
                g = m_grant[j];
                if (s_valid_i[g] && m_ready_i[j]) begin
                    fired[g]      = 1'b1;
                    fired_last[g] = s_last_i[g];
                    if (s_last_i[g]) m_locked[j] = 1'b0;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < S; k++) begin
                    g = (m_ptr[j] + k) % S;
                    if (!found && s_valid_i[g] && int'(s_dest_i[g]) == j) begin
                        found       = 1'b1;
                        m_grant[j]  = g;
                        m_ptr[j]    = (g + 1) % S;
                        m_locked[j] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic build_expected();
        for (int j = 0; j < M; j++) begin
            exp_grant[j] = IW'(m_grant[j]);
            exp_ready[j] = m_locked[j];
        end
    endtask

    // One clock: step the model, let the DUT take the edge, sample 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        build_expected();
    endtask

    task automatic idle_inputs();
        s_dest_i  = '0;
        s_valid_i = '0;
        s_last_i  = '0;
        m_ready_i = '1;
    endtask

    // Short reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst_in = 1'b0;
        #2 rst_in = 1'b1;
        model_reset();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b0;
        model_reset();
        #12;
        tests_run++;
        if (grant_o !== '0 || arbiter_ready_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: grant=%h ready=%b, expected grant=0 ready=000", grant_o, arbiter_ready_o);
        end
        rst_in = 1'b1;
        tick();
        tests_run++;
        if (grant_o !== exp_grant || arbiter_ready_o !== exp_ready) begin
            tests_failed++;
            $display("FAIL reset_idle: grant=%h ready=%b, expected grant=%h ready=%b", grant_o, arbiter_ready_o, exp_grant, exp_ready);
        end
    endtask

    task automatic test_single_packet();
        int beats = 0;
        int rdy_cycles = 0;
        bit done = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            s_valid_i[0] = !done;
            s_dest_i[0]  = 2'd1;
            s_last_i[0]  = (beats == 2);
            tick();
            if (fired[0]) begin
                beats++;
                if (fired_last[0]) done = 1'b1;
            end
            if (arbiter_ready_o[1] === 1'b1) rdy_cycles++;
            tests_run++;
            if (grant_o !== exp_grant || arbiter_ready_o !== exp_ready || arbiter_ready_o[0] !== 1'b0 || arbiter_ready_o[2] !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_packet c%0d: grant=%h ready=%b, expected grant=%h ready=%b", c, grant_o, arbiter_ready_o, exp_grant, exp_ready);
            end
        end
        tests_run++;
        if (rdy_cycles != 3 || grant_o[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_packet_len: ready cycles=%0d grant1=%b, expected 3 and 0", rdy_cycles, grant_o[1]);
        end
    endtask

    task automatic test_alternate();
        int seq[$];
        do_reset();
        s_valid_i   = 2'b11;
        s_last_i    = 2'b11;
        s_dest_i[0] = 2'd2;
        s_dest_i[1] = 2'd2;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (arbiter_ready_o[2] === 1'b1) seq.push_back(int'(grant_o[2]));
            tests_run++;
            if (grant_o !== exp_grant || arbiter_ready_o !== exp_ready || arbiter_ready_o[2] !== ((c % 2) == 0)) begin
                tests_failed++;
                $display("FAIL alternate c%0d: grant=%h ready=%b, expected grant=%h ready=%b", c, grant_o, arbiter_ready_o, exp_grant, exp_ready);
            end
        end
        tests_run++;
        if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
            tests_failed++;
            $display("FAIL alternate_order: got %0d grants %p, expected 0,1,0,1", seq.size(), seq);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            s_dest_i[0]  = 2'd0;
            s_dest_i[1]  = 2'd0;
            s_valid_i[1] = (c <= 1) || (c == 6);
            s_last_i[1]  = (c == 6);
            s_valid_i[0] = (c >= 1);
            s_last_i[0]  = 1'b0;
            m_ready_i[0] = (c >= 2 && c <= 5) ? c[0] : 1'b1;
            tick();
            tests_run++;
            if (grant_o !== exp_grant || arbiter_ready_o !== exp_ready) begin
                tests_failed++;
                $display("FAIL stall c%0d: grant=%h ready=%b, expected grant=%h ready=%b", c, grant_o, arbiter_ready_o, exp_grant, exp_ready);
            end
            tests_run++;
            if ((c <= 5 && (grant_o[0] !== 1'b1 || arbiter_ready_o[0] !== 1'b1)) ||
                (c == 6 && arbiter_ready_o[0] !== 1'b0) ||
                (c == 7 && (grant_o[0] !== 1'b0 || arbiter_ready_o[0] !== 1'b1))) begin
                tests_failed++;
                $display("FAIL stall_hold c%0d: grant0=%b ready0=%b", c, grant_o[0], arbiter_ready_o[0]);
            end
        end
    endtask

    task automatic test_parallel();
        do_reset();
        s_valid_i   = 2'b11;
        s_dest_i[0] = 2'd0;
        s_dest_i[1] = 2'd2;
        tick();
        tests_run++;
        if (grant_o !== exp_grant || arbiter_ready_o !== exp_ready || arbiter_ready_o !== 3'b101 || grant_o[0] !== 1'b0 || grant_o[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL parallel: grant=%h ready=%b, expected grant0=0 grant2=1 ready=101", grant_o, arbiter_ready_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        s_valid_i   = 2'b11;
        s_dest_i[0] = 2'd1;
        s_dest_i[1] = 2'd2;
        tick();
        tick();
        #3 rst_in = 1'b0;
        #1;
        tests_run++;
        if (grant_o !== '0 || arbiter_ready_o !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: grant=%h ready=%b, expected grant=0 ready=000", grant_o, arbiter_ready_o);
        end
        model_reset();
        #1 rst_in = 1'b1;
        s_dest_i[1] = 2'd1;
        tick();
        tests_run++;
        if (grant_o !== exp_grant || arbiter_ready_o !== exp_ready || grant_o[1] !== 1'b0 || arbiter_ready_o[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_grant: grant=%h ready=%b, expected grant=%h ready=%b", grant_o, arbiter_ready_o, exp_grant, exp_ready);
        end
    endtask

    task automatic test_random();
        int pkt_dest[S];
        int pkt_len[S];
        int beat[S];
        int errs = 0;
        do_reset();
        for (int i = 0; i < S; i++) begin
            pkt_dest[i] = int'($urandom_range(0, M - 1));
            pkt_len[i]  = int'($urandom_range(1, 4));
            beat[i]     = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < S; i++) begin
                s_dest_i[i]  = DW'(pkt_dest[i]);
                s_valid_i[i] = ($urandom_range(0, 3) != 0);
                s_last_i[i]  = (beat[i] == pkt_len[i] - 1);
            end
            m_ready_i = M'($urandom);
            tick();
            tests_run++;
            if (grant_o !== exp_grant || arbiter_ready_o !== exp_ready) begin
                tests_failed++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL random c%0d: grant=%h ready=%b, expected grant=%h ready=%b", c, grant_o, arbiter_ready_o, exp_grant, exp_ready);
                end
            end
            for (int i = 0; i < S; i++) begin
                if (fired[i]) begin
                    if (fired_last[i]) begin
                        pkt_dest[i] = int'($urandom_range(0, M - 1));
                        pkt_len[i]  = int'($urandom_range(1, 4));
                        beat[i]     = 0;
                    end else begin
                        beat[i]++;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_alternate();
        test_stall();
        test_parallel();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
